// File: rtl/fir_sweep_ctrl.sv
// Sequencer for ReConf_FirFilter: coefficient-RAM write sessions from a
// valid/ready beat stream, and a per-strobe RAM read sweep with MAC enables.
`timescale 1ns/1ps
module fir_sweep_ctrl #(
    parameter int NUM_TAP  = 10,
    parameter int NUM_BANK = 2
) (
    input  logic        iClk12M,
    input  logic        iRsn,
    input  logic        iEnSample600k,
    input  logic [1:0]  iBankSel,
    input  logic        iCoeffWrValid,
    output logic        oCoeffWrReady,
    input  logic [5:0]  iCoeffWrAddr,
    input  logic [15:0] iCoeffWrData,
    output logic        oCoeffUpdateFlag,
    output logic        oCsnRam,
    output logic        oWrnRam,
    output logic [5:0]  oAddrRam,
    output logic [15:0] oWtDtRam,
    output logic        oEnMul,
    output logic        oEnAddAcc,
    output logic        oSweepDone,
    output logic        oSampleMiss,
    output logic        oWrErr
);

    typedef enum logic [2:0] {IDLE, RD, UPD_PRE, UPD_WR, UPD_POST} state_t;

    localparam logic [4:0] TAP_N    = 5'(NUM_TAP);
    localparam logic [2:0] BANK_N   = 3'(NUM_BANK);
    localparam logic [1:0] BANK_MAX = 2'(NUM_BANK - 1);
    localparam logic [4:0] DONE_CNT = 5'(NUM_TAP + 2);

    state_t      state;
    logic [4:0]  cnt;
    logic [1:0]  bank;
    logic [2:0]  vldPipe;
    logic        readNow;
    logic        wrAccept;
    logic        wrInRange;
    logic [1:0]  bankClamp;

    assign readNow   = (state == RD) && (cnt < TAP_N);
    assign wrAccept  = (state == UPD_WR) && iCoeffWrValid && oCoeffWrReady;
    assign wrInRange = ({1'b0, iCoeffWrAddr[3:0]} < TAP_N) &&
                       ({1'b0, iCoeffWrAddr[5:4]} < BANK_N);
    assign bankClamp = ({1'b0, iBankSel} >= BANK_N) ? BANK_MAX : iBankSel;

    // Read issue -> multiply -> accumulate, one cycle apart
    assign oEnMul    = vldPipe[1];
    assign oEnAddAcc = vldPipe[2];

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state            <= IDLE;
            cnt              <= '0;
            bank             <= '0;
            vldPipe          <= '0;
            oCoeffWrReady    <= 1'b0;
            oCoeffUpdateFlag <= 1'b0;
            oCsnRam          <= 1'b1;
            oWrnRam          <= 1'b1;
            oAddrRam         <= '0;
            oWtDtRam         <= '0;
            oSweepDone       <= 1'b0;
            oSampleMiss      <= 1'b0;
            oWrErr           <= 1'b0;
        end else begin
            oCsnRam     <= 1'b1;
            oWrnRam     <= 1'b1;
            oAddrRam    <= '0;
            oWtDtRam    <= '0;
            oSweepDone  <= 1'b0;
            oSampleMiss <= 1'b0;
            oWrErr      <= 1'b0;
            vldPipe     <= {vldPipe[1:0], readNow};

            if (iEnSample600k && state != IDLE)
                oSampleMiss <= 1'b1;

            if (readNow) begin
                oCsnRam  <= 1'b0;
                oAddrRam <= {bank, cnt[3:0]};
            end

            case (state)
                IDLE: begin
                    // Strobe wins a tie; a pending write waits with ready low
                    if (iEnSample600k) begin
                        state <= RD;
                        cnt   <= '0;
                        bank  <= bankClamp;
                    end else if (iCoeffWrValid) begin
                        state            <= UPD_PRE;
                        oCoeffUpdateFlag <= 1'b1;
                    end
                end
                RD: begin
                    if (cnt == DONE_CNT) begin
                        oSweepDone <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                UPD_PRE: begin
                    oCoeffWrReady <= 1'b1;
                    state         <= UPD_WR;
                end
                UPD_WR: begin
                    if (!iCoeffWrValid) begin
                        oCoeffWrReady <= 1'b0;
                        cnt           <= '0;
                        state         <= UPD_POST;
                    end else if (wrAccept) begin
                        if (wrInRange) begin
                            oCsnRam  <= 1'b0;
                            oWrnRam  <= 1'b0;
                            oAddrRam <= iCoeffWrAddr;
                            oWtDtRam <= iCoeffWrData;
                        end else begin
                            oWrErr <= 1'b1;
                        end
                    end
                end
                UPD_POST: begin
                    if (cnt == 5'd1) begin
                        oCoeffUpdateFlag <= 1'b0;
                        state            <= IDLE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sweep_ctrl.sv
// Randomized bench for fir_sweep_ctrl; expected outputs come from cycle
// timelines derived directly from the sweep/session timing rules.
`timescale 1ns/1ps
module tb_fir_sweep_ctrl;

    localparam int NT = 10;
    localparam int NB = 2;

    logic        iClk12M = 1'b0;
    logic        iRsn;
    logic        iEnSample600k;
    logic [1:0]  iBankSel;
    logic        iCoeffWrValid;
    logic        oCoeffWrReady;
    logic [5:0]  iCoeffWrAddr;
    logic [15:0] iCoeffWrData;
    logic        oCoeffUpdateFlag, oCsnRam, oWrnRam;
    logic [5:0]  oAddrRam;
    logic [15:0] oWtDtRam;
    logic        oEnMul, oEnAddAcc, oSweepDone, oSampleMiss, oWrErr;

    int nChecks = 0;
    int nErrors = 0;

    logic [5:0]  bAddr[32];
    logic [15:0] bData[32];

    logic [30:0] obs;
    assign obs = {oCsnRam, oWrnRam, oAddrRam, oWtDtRam, oEnMul, oEnAddAcc,
                  oSweepDone, oSampleMiss, oWrErr, oCoeffUpdateFlag, oCoeffWrReady};

    fir_sweep_ctrl #(.NUM_TAP(NT), .NUM_BANK(NB)) dut (
        .iClk12M(iClk12M), .iRsn(iRsn), .iEnSample600k(iEnSample600k),
        .iBankSel(iBankSel), .iCoeffWrValid(iCoeffWrValid),
        .oCoeffWrReady(oCoeffWrReady), .iCoeffWrAddr(iCoeffWrAddr),
        .iCoeffWrData(iCoeffWrData), .oCoeffUpdateFlag(oCoeffUpdateFlag),
        .oCsnRam(oCsnRam), .oWrnRam(oWrnRam), .oAddrRam(oAddrRam),
        .oWtDtRam(oWtDtRam), .oEnMul(oEnMul), .oEnAddAcc(oEnAddAcc),
        .oSweepDone(oSweepDone), .oSampleMiss(oSampleMiss), .oWrErr(oWrErr)
    );

    always #5 iClk12M = ~iClk12M;

    function automatic logic [30:0] mk(logic csn, logic wrn, logic [5:0] a, logic [15:0] d,
                                       logic mul, logic acc, logic done, logic miss,
                                       logic err, logic flag, logic rdy);
        return {csn, wrn, a, d, mul, acc, done, miss, err, flag, rdy};
    endfunction

    localparam logic [30:0] IDLE_VEC = {1'b1, 1'b1, 29'd0};

    task automatic chk(input string tag, input logic [30:0] got, input logic [30:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Strobe sampled at the next edge (cycle 0); cycles 0..NT+3 compared.
    task automatic runSweep(input logic [1:0] sel, input int missAt);
        int bk;
        logic rdAct;
        logic [5:0] a;
        bk = (int'(sel) >= NB) ? NB - 1 : int'(sel);
        iBankSel = sel;
        iEnSample600k = 1'b1;
        for (int k = 0; k <= NT + 3; k++) begin
            @(posedge iClk12M);
            #1;
            iEnSample600k = (missAt != 0 && k == missAt - 1);
            @(negedge iClk12M);
            rdAct = (k >= 1 && k <= NT);
            a = rdAct ? 6'(bk * 16 + (k - 1)) : 6'd0;
            chk("sweep", obs, mk(!rdAct, 1'b1, a, 16'd0, (k >= 2 && k <= NT + 1),
                (k >= 3 && k <= NT + 2), (k == NT + 3), (missAt != 0 && k == missAt),
                1'b0, 1'b0, 1'b0));
        end
    endtask

    // Beats bAddr/bData[0..n-1] back to back; valid seen in IDLE at cycle 0.
    task automatic runSession(input int n, input int missAt);
        logic wrCyc, inR;
        int i;
        iCoeffWrValid = 1'b1;
        iCoeffWrAddr  = bAddr[0];
        iCoeffWrData  = bData[0];
        for (int c = 0; c <= n + 5; c++) begin
            @(posedge iClk12M);
            #1;
            if (c >= 2 && c - 1 < n) begin
                iCoeffWrAddr = bAddr[c - 1];
                iCoeffWrData = bData[c - 1];
            end else if (c == n + 1) begin
                iCoeffWrValid = 1'b0;
            end
            iEnSample600k = (missAt != 0 && c == missAt - 1);
            @(negedge iClk12M);
            i = c - 2;
            wrCyc = (c >= 2 && i < n);
            inR = 1'b0;
            if (wrCyc) inR = (int'(bAddr[i][3:0]) < NT) && (int'(bAddr[i][5:4]) < NB);
            chk("session", obs, mk(!(wrCyc && inR), !(wrCyc && inR),
                (wrCyc && inR) ? bAddr[i] : 6'd0, (wrCyc && inR) ? bData[i] : 16'd0,
                1'b0, 1'b0, 1'b0, (missAt != 0 && c == missAt), wrCyc && !inR,
                (c <= n + 3), (c >= 1 && c <= n + 1)));
        end
    endtask

    task automatic idleGap(input int cyc);
        for (int k = 0; k < cyc; k++) begin
            @(negedge iClk12M);
            chk("idle", obs, IDLE_VEC);
        end
    endtask

    initial begin
        int n, miss;
        logic bad;
        iRsn = 1'b0;
        iEnSample600k = 1'b0;
        iBankSel = 2'd0;
        iCoeffWrValid = 1'b0;
        iCoeffWrAddr = '0;
        iCoeffWrData = '0;
        repeat (3) @(posedge iClk12M);
        #1 chk("reset", obs, IDLE_VEC);
        @(negedge iClk12M) iRsn = 1'b1;
        idleGap(2);

        // Directed session: taps 0..9 of bank 0
        for (int i = 0; i < 10; i++) begin
            bAddr[i] = 6'(i);
            bData[i] = 16'h0A00 + 16'(i);
        end
        runSession(10, 0);
        idleGap(2);

        runSweep(2'd1, 0);
        idleGap(2);
        runSweep(2'd3, 0);
        idleGap(2);

        // Out-of-range tap and bank beats among a valid one
        bAddr[0] = 6'h05; bData[0] = 16'h1234;
        bAddr[1] = 6'h0C; bData[1] = 16'hBEEF;
        bAddr[2] = 6'h23; bData[2] = 16'hCAFE;
        runSession(3, 0);
        idleGap(1);

        // Strobe during UPD_WR
        runSession(3, 3);
        idleGap(1);

        // Strobe during RD
        runSweep(2'd0, 6);
        idleGap(1);

        // Collision: sweep first, then the waiting write session
        bAddr[0] = 6'h13; bData[0] = 16'h5A5A;
        bAddr[1] = 6'h02; bData[1] = 16'hA5A5;
        iCoeffWrValid = 1'b1;
        iCoeffWrAddr = bAddr[0];
        iCoeffWrData = bData[0];
        runSweep(2'd1, 0);
        runSession(2, 0);
        idleGap(1);

        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                miss = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, NT + 1)) : 0;
                runSweep(2'($urandom_range(0, 3)), miss);
            end else begin
                n = $urandom_range(1, 12);
                for (int i = 0; i < n; i++) begin
                    bad = ($urandom_range(0, 4) == 0);
                    if (bad && $urandom_range(0, 1) == 1)
                        bAddr[i] = {2'($urandom_range(0, NB - 1)), 4'($urandom_range(NT, 15))};
                    else if (bad)
                        bAddr[i] = {2'($urandom_range(NB, 3)), 4'($urandom_range(0, NT - 1))};
                    else
                        bAddr[i] = {2'($urandom_range(0, NB - 1)), 4'($urandom_range(0, NT - 1))};
                    bData[i] = 16'($urandom);
                end
                miss = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, n + 1)) : 0;
                runSession(n, miss);
            end
            idleGap(int'($urandom_range(1, 3)));
        end

        // Reset in the middle of a sweep
        iBankSel = 2'd1;
        iEnSample600k = 1'b1;
        @(posedge iClk12M);
        #1 iEnSample600k = 1'b0;
        repeat (4) @(negedge iClk12M);
        #2 iRsn = 1'b0;
        #1 chk("rstMid", obs, IDLE_VEC);
        @(negedge iClk12M) iRsn = 1'b1;
        idleGap(2);
        runSweep(2'd0, 0);
        idleGap(1);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
